// File: rtl/beam_pwr_acc.sv
`default_nettype none
// ============================================================================
// beam_pwr_acc : per-beam |x|^2 windowed accumulator with 16-beam serial output
// Rev 1.0
// ============================================================================
module beam_pwr_acc #(
  parameter  int BEAM  = 16,
  parameter  int IW    = 16,
  parameter  int LEN_W = 12,
  localparam int AW    = 2*IW + LEN_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [BEAM*2*IW-1:0]   i_beam_sum,
  input  logic                   i_rvalid,
  input  logic                   i_sop,
  input  logic [LEN_W-1:0]       i_acc_len,
  output logic [AW-1:0]          o_pwr,
  output logic [3:0]             o_beam_idx,
  output logic                   o_pwr_valid,
  output logic                   o_last,
  output logic                   o_busy
);

  localparam int PW = 2*IW;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]        r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_cnt, r_n_eff;
  logic              w_accept, w_last, w_sop_acc;

  logic signed [PW-1:0] w_re [BEAM];
  logic signed [PW-1:0] w_im [BEAM];

  logic [PW-1:0]     r_re2  [BEAM];
  logic [PW-1:0]     r_im2  [BEAM];
  logic [PW-1:0]     r_p    [BEAM];
  logic [AW-1:0]     r_acc  [BEAM];
  logic [AW-1:0]     r_snap [BEAM];

  logic              r_s1_vld, r_s1_sop, r_s1_last;
  logic              r_s2_vld, r_s2_sop, r_s2_last;
  logic              w_snap_ld;
  logic              r_ser_act;
  logic [3:0]        r_ser_idx;

  // ---------------- window control FSM ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n_eff <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sop_acc) begin
        r_cnt   <= LEN_W'(1);
        // Short windows are stretched so the serializer drains before the next window ends.
        r_n_eff <= (i_acc_len < LEN_W'(BEAM)) ? LEN_W'(BEAM) : i_acc_len;
      end else if (w_accept) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_sop_acc) w_state_nxt = S_ACC;
      S_ACC: begin
        if (w_sop_acc)   w_state_nxt = S_ACC;
        else if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sop_acc = i_rvalid && i_sop;
    w_accept  = i_rvalid && (i_sop || (r_state == S_ACC));
    w_last    = i_rvalid && !i_sop && (r_state == S_ACC) &&
                ((r_cnt + LEN_W'(1)) == r_n_eff);
    o_busy    = (r_state == S_ACC);
  end

  // ---------------- power pipeline and accumulators ----------------
  always_comb begin
    for (int b = 0; b < BEAM; b++) begin
      w_re[b] = {{IW{i_beam_sum[PW*b+PW-1]}}, i_beam_sum[PW*b+IW +: IW]};
      w_im[b] = {{IW{i_beam_sum[PW*b+IW-1]}}, i_beam_sum[PW*b +: IW]};
    end
  end

  assign w_snap_ld = r_s2_vld && r_s2_last;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_sop  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_sop  <= 1'b0;
      r_s2_last <= 1'b0;
      for (int b = 0; b < BEAM; b++) begin
        r_re2[b]  <= '0;
        r_im2[b]  <= '0;
        r_p[b]    <= '0;
        r_acc[b]  <= '0;
        r_snap[b] <= '0;
      end
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_sop  <= w_sop_acc;
      r_s1_last <= w_last;
      r_s2_vld  <= r_s1_vld;
      r_s2_sop  <= r_s1_sop;
      r_s2_last <= r_s1_last;
      for (int b = 0; b < BEAM; b++) begin
        if (w_accept) begin
          r_re2[b] <= w_re[b] * w_re[b];
          r_im2[b] <= w_im[b] * w_im[b];
        end
        if (r_s1_vld) r_p[b] <= r_re2[b] + r_im2[b];
        if (r_s2_vld) begin
          r_acc[b] <= r_s2_sop ? AW'(r_p[b]) : (r_acc[b] + AW'(r_p[b]));
        end
        if (w_snap_ld) r_snap[b] <= r_acc[b] + AW'(r_p[b]);
      end
    end
  end

  // ---------------- serializer ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ser_act   <= 1'b0;
      r_ser_idx   <= '0;
      o_pwr       <= '0;
      o_beam_idx  <= '0;
      o_pwr_valid <= 1'b0;
      o_last      <= 1'b0;
    end else begin
      if (r_ser_act) begin
        o_pwr       <= r_snap[r_ser_idx];
        o_beam_idx  <= r_ser_idx;
        o_pwr_valid <= 1'b1;
        o_last      <= (r_ser_idx == 4'd15);
        r_ser_idx   <= r_ser_idx + 4'd1;
        if (r_ser_idx == 4'd15) r_ser_act <= 1'b0;
      end else begin
        o_pwr       <= '0;
        o_beam_idx  <= '0;
        o_pwr_valid <= 1'b0;
        o_last      <= 1'b0;
      end
      // A new snapshot may land on the same edge the previous burst emits beam 15.
      if (w_snap_ld) begin
        r_ser_act <= 1'b1;
        r_ser_idx <= '0;
      end
    end
  end

endmodule
`default_nettype wire
